// File: rtl/uart_rx_stream.sv
// uart_rx_stream: 16x oversampling UART receiver feeding a one-deep valid/ready holding register.
// Frame format is latched at the start edge so mid-frame configuration changes are ignored.
module uart_rx_stream (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic [15:0] div,
    input  logic [3:0]  length,
    input  logic        parity_en,
    input  logic        parity_type,
    input  logic        stop2,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overrun,
    input  logic        clr_ovr,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DELIVER} state_t;
    state_t      state_q, state_d;
    logic [1:0]  sync_q, sync_d;
    logic        rxd_p_q, rxd_p_d;
    logic [15:0] tick_q, tick_d, div_q, div_d;
    logic [3:0]  sample_q, sample_d, len_q, len_d;
    logic [2:0]  bit_q, bit_d;
    logic        par_en_q, par_en_d, par_type_q, par_type_d, stop2_q, stop2_d;
    logic [7:0]  shift_q, shift_d, m_data_q, m_data_d;
    logic        perr_q, perr_d, ferr_q, ferr_d;
    logic        m_valid_q, m_valid_d, parity_err_q, parity_err_d;
    logic        frame_err_q, frame_err_d, overrun_q, overrun_d, busy_q, busy_d;
    logic        rxd_s, tick, mid, last, load;

    always_comb begin
        rxd_s = sync_q[1];
        tick = tick_q == div_q;
        mid = tick && sample_q == 4'd7;
        last = tick && sample_q == 4'd15;
        load = !m_valid_q || m_ready;
        sync_d = {sync_q[0], rxd};
        rxd_p_d = rxd_s;
        state_d = state_q;
        tick_d = tick ? 16'd0 : tick_q + 16'd1;
        sample_d = tick ? sample_q + 4'd1 : sample_q;
        bit_d = bit_q;
        div_d = div_q;
        len_d = len_q;
        par_en_d = par_en_q;
        par_type_d = par_type_q;
        stop2_d = stop2_q;
        shift_d = shift_q;
        perr_d = perr_q;
        ferr_d = ferr_q;
        m_data_d = m_data_q;
        m_valid_d = m_valid_q && !m_ready;
        parity_err_d = parity_err_q;
        frame_err_d = frame_err_q;
        overrun_d = overrun_q && !clr_ovr;
        case (state_q)
            IDLE: begin
                tick_d = '0;
                sample_d = '0;
                bit_d = '0;
                // only a fresh falling edge starts a frame, never a line already low
                if (rxd_p_q && !rxd_s) begin
                    state_d = START;
                    div_d = div;
                    len_d = (length < 4'd5 || length > 4'd8) ? 4'd8 : length;
                    par_en_d = parity_en;
                    par_type_d = parity_type;
                    stop2_d = stop2;
                    shift_d = '0;
                    perr_d = 1'b0;
                    ferr_d = 1'b0;
                end
            end
            START: state_d = (mid && rxd_s) ? IDLE : last ? DATA : START;
            DATA: begin
                if (mid) shift_d[bit_q] = rxd_s;
                if (last) begin
                    bit_d = bit_q + 3'd1;
                    if ({1'b0, bit_q} == len_q - 4'd1) state_d = par_en_q ? PARITY : STOP1;
                end
            end
            PARITY: begin
                if (mid) perr_d = rxd_s != (par_type_q ? ^shift_q : ~^shift_q);
                if (last) state_d = STOP1;
            end
            STOP1: begin
                if (mid) begin
                    ferr_d = ferr_q | !rxd_s;
                    if (!stop2_q) state_d = DELIVER;
                end
                if (last) state_d = STOP2;
            end
            STOP2: begin
                if (mid) begin
                    ferr_d = ferr_q | !rxd_s;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                state_d = IDLE;
                if (load) begin
                    m_data_d = shift_q;
                    m_valid_d = 1'b1;
                    parity_err_d = perr_q;
                    frame_err_d = ferr_q;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q <= 2'b11;
            rxd_p_q <= 1'b1;
            tick_q <= '0;
            sample_q <= '0;
            bit_q <= '0;
            div_q <= '0;
            len_q <= 4'd8;
            par_en_q <= 1'b0;
            par_type_q <= 1'b0;
            stop2_q <= 1'b0;
            shift_q <= '0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            m_data_q <= '0;
            m_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q <= sync_d;
            rxd_p_q <= rxd_p_d;
            tick_q <= tick_d;
            sample_q <= sample_d;
            bit_q <= bit_d;
            div_q <= div_d;
            len_q <= len_d;
            par_en_q <= par_en_d;
            par_type_q <= par_type_d;
            stop2_q <= stop2_d;
            shift_q <= shift_d;
            perr_q <= perr_d;
            ferr_q <= ferr_d;
            m_data_q <= m_data_d;
            m_valid_q <= m_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q <= frame_err_d;
            overrun_q <= overrun_d;
            busy_q <= busy_d;
        end
    end

    assign m_data = m_data_q;
    assign m_valid = m_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err = frame_err_q;
    assign overrun = overrun_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_uart_rx_stream.sv
// tb_uart_rx_stream: directed and random frames against a line-format model of the receiver.
module tb_uart_rx_stream;
    logic        clk = 1'b0, rst = 1'b1, rxd = 1'b1;
    logic [15:0] div = 16'd3;
    logic [3:0]  length = 4'd8;
    logic        parity_en = 1'b0, parity_type = 1'b0, stop2 = 1'b0;
    logic        m_ready = 1'b1, clr_ovr = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid, parity_err, frame_err, overrun, busy;
    int          checks = 0, errors = 0;
    logic [9:0]  got_q[$];

    always #5 clk = ~clk;

    uart_rx_stream dut (
        .clk(clk), .rst(rst), .rxd(rxd), .div(div), .length(length),
        .parity_en(parity_en), .parity_type(parity_type), .stop2(stop2),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
        .clr_ovr(clr_ovr), .busy(busy)
    );

    // every cycle with valid and ready high is one consumed frame
    always @(negedge clk) if (m_valid && m_ready) got_q.push_back({m_data, parity_err, frame_err});

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] model(input logic [7:0] b, input logic [3:0] len, input logic pen,
                                         input logic ptype, input logic pbit, input logic s2,
                                         input logic sb1, input logic sb2);
        int n, ones;
        logic [7:0] d;
        logic want;
        n = (len >= 4'd5 && len <= 4'd8) ? int'(len) : 8;
        d = b & 8'((1 << n) - 1);
        ones = $countones(d);
        want = ptype ? (ones % 2 == 1) : (ones % 2 == 0);
        return {d, pen && (pbit != want), !sb1 || (s2 && !sb2)};
    endfunction

    task automatic send(input logic [7:0] b, input logic [3:0] len, input logic pen, input logic ptype,
                        input logic pbit, input logic s2, input logic sb1, input logic sb2,
                        input logic scramble, input logic [15:0] dv);
        int n, bc;
        logic q[$];
        n = (len >= 4'd5 && len <= 4'd8) ? int'(len) : 8;
        bc = 16 * (int'(dv) + 1);
        q.push_back(1'b0);
        for (int i = 0; i < n; i++) q.push_back(b[i]);
        if (pen) q.push_back(pbit);
        q.push_back(sb1);
        if (s2) q.push_back(sb2);
        div = dv;
        length = len;
        parity_en = pen;
        parity_type = ptype;
        stop2 = s2;
        foreach (q[i]) begin
            rxd = q[i];
            repeat (bc) @(negedge clk);
            if (scramble && i == 0) begin
                {length, parity_en, parity_type, stop2} = 7'($urandom);
                div = 16'($urandom_range(1, 7));
            end
        end
        rxd = 1'b1;
    endtask

    task automatic frame(input string tag, input logic [7:0] b, input logic [3:0] len, input logic pen,
                         input logic ptype, input logic pbit, input logic s2, input logic sb1,
                         input logic sb2, input logic scramble, input logic [15:0] dv);
        logic [9:0] exp, got;
        exp = model(b, len, pen, ptype, pbit, s2, sb1, sb2);
        send(b, len, pen, ptype, pbit, s2, sb1, sb2, scramble, dv);
        for (int i = 0; i < 16 && got_q.size() == 0; i++) @(negedge clk);
        check({tag, "_count"}, got_q.size(), 1);
        got = 10'h3ff;
        if (got_q.size() > 0) got = got_q.pop_front();
        check(tag, got, exp);
        got_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        logic [3:0] len;
        logic pen, ptype, pbit, s2, sb1, sb2, last_low;
        logic [9:0] got;
        repeat (3) @(negedge clk);
        check("reset_outputs", {m_data, m_valid, parity_err, frame_err, overrun, busy}, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        frame("8n1_a5", 8'hA5, 4'd8, 0, 0, 0, 0, 1, 1, 0, 16'd3);
        repeat (5) @(negedge clk);
        frame("7o_35_p1", 8'h35, 4'd7, 1, 1, 1, 0, 1, 1, 0, 16'd3);
        frame("7o_35_p0", 8'h35, 4'd7, 1, 1, 0, 0, 1, 1, 0, 16'd3);
        frame("8n2_0f_ferr", 8'h0F, 4'd8, 0, 0, 0, 1, 1, 0, 0, 16'd3);
        repeat (20) @(negedge clk);

        rxd = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_busy", busy, 1);
        rxd = 1'b1;
        repeat (64) @(negedge clk);
        check("glitch_idle", busy, 0);
        check("glitch_nodata", got_q.size(), 0);

        m_ready = 1'b0;
        send(8'h11, 4'd8, 0, 0, 0, 0, 1, 1, 0, 16'd3);
        repeat (4) @(negedge clk);
        check("hold_first", {m_valid, m_data, overrun}, {1'b1, 8'h11, 1'b0});
        send(8'h22, 4'd8, 0, 0, 0, 0, 1, 1, 0, 16'd3);
        repeat (4) @(negedge clk);
        check("overrun_set", {m_valid, m_data, overrun}, {1'b1, 8'h11, 1'b1});
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        @(negedge clk);
        check("overrun_clr", {m_valid, overrun}, {1'b1, 1'b0});
        @(posedge clk);
        #1 m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
        @(negedge clk);
        check("consume_valid", m_valid, 0);
        got = 10'h3ff;
        if (got_q.size() > 0) got = got_q.pop_front();
        check("consume_data", got[9:2], 8'h11);
        got_q.delete();
        m_ready = 1'b1;
        repeat (10) @(negedge clk);

        div = 16'd3;
        length = 4'd8;
        parity_en = 1'b0;
        stop2 = 1'b0;
        rxd = 1'b0;
        repeat (64) @(negedge clk);
        rxd = 1'b1;
        repeat (192) @(negedge clk);
        check("mid_frame_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs", {m_data, m_valid, parity_err, frame_err, overrun, busy}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (640) @(negedge clk);
        check("reset_nodata", got_q.size(), 0);
        frame("after_reset_3c", 8'h3C, 4'd8, 0, 0, 0, 0, 1, 1, 0, 16'd3);

        last_low = 1'b0;
        for (int k = 0; k < 30; k++) begin
            b = 8'($urandom);
            len = ($urandom_range(0, 6) == 0) ? 4'($urandom) : 4'($urandom_range(5, 8));
            pen = 1'($urandom);
            ptype = 1'($urandom);
            s2 = 1'($urandom);
            pbit = 1'($urandom);
            sb1 = $urandom_range(0, 4) != 0;
            sb2 = $urandom_range(0, 4) != 0;
            repeat ((last_low ? 40 : 0) + $urandom_range(0, 8)) @(negedge clk);
            frame("random", b, len, pen, ptype, pbit, s2, sb1, sb2, 1'($urandom),
                  16'($urandom_range(1, 3)));
            last_low = s2 ? !sb2 : !sb1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
